multi_channel_pulse_generator: RTL and testbench

//   Parametrised successor to the single-channel tick generator: N independent periodic

---
 rtl/pulse_gen_pkg.sv | 17 +
 rtl/pulse_gen_channel.sv | 91 +++++++++
 rtl/multi_channel_pulse_generator.sv | 67 ++++++
 tb/tb_multi_channel_pulse_generator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types, constants and helpers for the multi-channel pulse generator.
package pulse_gen_pkg;

  localparam int unsigned DEFAULT_PERIOD_C = 2;
  localparam int unsigned MAX_CHANNELS     = 16;

  typedef enum logic [0:0] {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

  // Channel index width, at least one bit so a single-channel build still has a port.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: period register, phase counter and registered pulse/active outputs.
// Optional high-time register when PULSE_GEN_DUTY_EN is defined.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             period_ld,
  input  logic [WIDTH-1:0] period_data,
`ifdef PULSE_GEN_DUTY_EN
  input  logic             duty_ld,
  input  logic [WIDTH-1:0] duty_data,
`endif
  output logic             pulse,
  output logic             active
);

  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  ch_state_e        st_q, st_d;
  logic             phase_reset;
  logic             wrap_pulse;
  logic             run_pulse;

`ifdef PULSE_GEN_DUTY_EN
  logic [WIDTH-1:0] duty_q, duty_d;

  assign phase_reset = restart | period_ld | duty_ld;
  assign wrap_pulse  = (duty_q != '0);
  // Next count is cnt+1; stay high while still inside the high time.
  assign run_pulse   = ((cnt_q + WIDTH'(1)) < duty_q);

  always_comb begin
    duty_d = duty_q;
    if (duty_ld) duty_d = duty_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_q <= WIDTH'(1);
    else     duty_q <= duty_d;
  end
`else
  assign phase_reset = restart | period_ld;
  assign wrap_pulse  = 1'b1;
  assign run_pulse   = 1'b0;
`endif

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    st_d     = (en && (period_q != '0)) ? CH_RUN : CH_IDLE;
    if (period_ld) period_d = period_data;

    if (phase_reset) begin
      cnt_d = '0;
    end else if (!en || (period_q == '0)) begin
      cnt_d = '0;
    end else if (cnt_q == (period_q - WIDTH'(1))) begin
      cnt_d   = '0;
      pulse_d = wrap_pulse;
    end else begin
      cnt_d   = cnt_q + WIDTH'(1);
      pulse_d = run_pulse;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= WIDTH'(DEFAULT_PERIOD);
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      st_q     <= CH_IDLE;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      st_q     <= st_d;
    end
  end

  assign pulse  = pulse_q;
  assign active = (st_q == CH_RUN);

endmodule

// File: rtl/multi_channel_pulse_generator.sv
// N independent periodic pulse channels with programmable periods and global phase sync.
// Define PULSE_GEN_DUTY_EN to add per-channel programmable high time (duty_wr/duty_data).
module multi_channel_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C,
  localparam int unsigned IdxW          = ch_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                period_wr,
  input  logic [IdxW-1:0]     period_ch,
  input  logic [WIDTH-1:0]    period_data,
`ifdef PULSE_GEN_DUTY_EN
  input  logic                duty_wr,
  input  logic [WIDTH-1:0]    duty_data,
`endif
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] active
);

  logic [CHANNELS-1:0] period_ld;
`ifdef PULSE_GEN_DUTY_EN
  logic [CHANNELS-1:0] duty_ld;
`endif

  // Indices at or above CHANNELS match no slot, so such writes are dropped.
  always_comb begin
    period_ld = '0;
`ifdef PULSE_GEN_DUTY_EN
    duty_ld   = '0;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (period_ch == IdxW'(i)) begin
        period_ld[i] = period_wr;
`ifdef PULSE_GEN_DUTY_EN
        duty_ld[i]   = duty_wr;
`endif
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_gen_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (en[g]),
      .restart     (sync),
      .period_ld   (period_ld[g]),
      .period_data (period_data),
`ifdef PULSE_GEN_DUTY_EN
      .duty_ld     (duty_ld[g]),
      .duty_data   (duty_data),
`endif
      .pulse       (pulse[g]),
      .active      (active[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_pulse_generator.sv
// Directed scenarios plus random traffic, checked against a run-length model of each channel.
// Five channels give a 3-bit index so out-of-range writes (5..7) are expressible.
module tb_multi_channel_pulse_generator;

  localparam int unsigned CH   = 5;
  localparam int unsigned W    = 32;
  localparam int unsigned DEF  = 2;
  localparam int unsigned IW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          sync;
  logic          period_wr;
  logic [IW-1:0] period_ch;
  logic [W-1:0]  period_data;
  logic [CH-1:0] pulse;
  logic [CH-1:0] active;
`ifdef PULSE_GEN_DUTY_EN
  logic          duty_wr   = 1'b0;
  logic [W-1:0]  duty_data = '0;
`endif

  int total = 0;
  int bad   = 0;

  // Model: a channel pulses when its count of consecutive running edges is a multiple of P.
  logic [W-1:0]    m_per [CH];
  longint unsigned m_run [CH];
  logic [CH-1:0]   exp_pulse;
  logic [CH-1:0]   exp_act;

  multi_channel_pulse_generator #(
    .CHANNELS       (CH),
    .WIDTH          (W),
    .DEFAULT_PERIOD (DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .period_wr   (period_wr),
    .period_ch   (period_ch),
    .period_data (period_data),
`ifdef PULSE_GEN_DUTY_EN
    .duty_wr     (duty_wr),
    .duty_data   (duty_data),
`endif
    .pulse       (pulse),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_per[i] = W'(DEF);
      m_run[i] = 0;
    end
    exp_pulse = '0;
    exp_act   = '0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      logic hit;
      hit        = period_wr && (int'(period_ch) == i);
      exp_act[i] = en[i] && (m_per[i] != 0);
      if (!sync && !hit && exp_act[i]) begin
        m_run[i]++;
        exp_pulse[i] = ((m_run[i] % longint'(m_per[i])) == 0);
      end else begin
        m_run[i]     = 0;
        exp_pulse[i] = 1'b0;
      end
      if (hit) m_per[i] = period_data;
    end
  endtask

  task automatic step(input logic [CH-1:0] en_v, input logic sync_v, input logic wr_v,
                      input logic [IW-1:0] ch_v, input logic [W-1:0] d_v, input string tag);
    en          = en_v;
    sync        = sync_v;
    period_wr   = wr_v;
    period_ch   = ch_v;
    period_data = d_v;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".pulse"}, pulse, exp_pulse);
    check({tag, ".active"}, active, exp_act);
  endtask

  task automatic run(input logic [CH-1:0] en_v, input int n, input string tag);
    for (int k = 0; k < n; k++) step(en_v, 1'b0, 1'b0, '0, '0, tag);
  endtask

  initial begin
    logic [CH-1:0] r_en;
    rst = 1'b1; en = '0; sync = 1'b0; period_wr = 1'b0; period_ch = '0; period_data = '0;
    model_reset();
    #2;
    check("reset.pulse", pulse, '0);
    check("reset.active", active, '0);
    #10 rst = 1'b0;

    // Default period on channel 0 only.
    run(5'b00001, 8, "t1");

    // Channel 2 with period 5.
    step(5'b00001, 1'b0, 1'b1, 3'd2, 32'd5, "t2wr");
    run(5'b00101, 16, "t2");

    // Channels 1 (P=7) and 3 (P=3), then a common sync.
    step(5'b00000, 1'b0, 1'b1, 3'd1, 32'd7, "t3wr1");
    step(5'b00000, 1'b0, 1'b1, 3'd3, 32'd3, "t3wr3");
    run(5'b01010, 5, "t3pre");
    step(5'b01010, 1'b1, 1'b0, '0, '0, "t3sync");
    run(5'b01010, 22, "t3");

    // Period 0 turns channel 0 off; period 1 keeps it high every cycle.
    step(5'b00001, 1'b0, 1'b1, 3'd0, 32'd0, "t4p0");
    run(5'b00001, 4, "t4off");
    step(5'b00001, 1'b0, 1'b1, 3'd0, 32'd1, "t4p1");
    run(5'b00001, 5, "t4on");

    // Out-of-range index writes must not touch any channel.
    step(5'b11111, 1'b0, 1'b1, 3'd5, 32'd0, "t5oor5");
    step(5'b11111, 1'b0, 1'b1, 3'd7, 32'd0, "t5oor7");
    run(5'b11111, 9, "t5run");

    // Sync and write together, then en dropped mid-period.
    step(5'b11111, 1'b1, 1'b1, 3'd4, 32'd4, "t5syncwr");
    run(5'b11111, 3, "t5a");
    run(5'b01111, 2, "t5drop");
    run(5'b11111, 6, "t5re");

    // Asynchronous reset away from the clock edge.
    rst = 1'b1;
    #1;
    check("t5rst.pulse", pulse, '0);
    check("t5rst.active", active, '0);
    model_reset();
    #1 rst = 1'b0;
    run(5'b11111, 6, "t5post");

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      r_en = CH'($urandom);
      step(($urandom_range(0, 9) == 0) ? '0 : r_en | CH'(1),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0),
           IW'($urandom_range(0, 7)),
           W'($urandom_range(0, 6)),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
